fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage of the OoO RISC-V core.
- Generates the PC stream into the instruction BRAM (1-cycle registered read) and collects the returned words in a small decoupling queue.
- Presents {pc, instr} to the fetch skid buffer over a valid/ready handshake.
- Accepts redirects from branch resolution / ROM flush. Exposes the PC wrap pulse and a fetched-instruction count for bench and trace use.

Parameters:
PC_W, 9, PC width in bytes; the PC wraps modulo 2^PC_W.
INSTR_W, 32, instruction word width.
DEPTH, 2, output queue entries (power of two, >=2).
RESET_PC, 0, PC fetched first after reset.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  PC_W  redirect target (bits [1:0] are ignored and treated as 0)
fetch_to_cache_en  in  out  1  BRAM read enable (issue this cycle)
fetch_to_cache_pc  out  PC_W  BRAM byte address; memory indexes pc[PC_W-1:2]
cache_rdata  in  INSTR_W  BRAM data, valid the cycle after an issue
fetch_to_skid_valid  out  1  queue head valid
fetch_to_skid_ready  in  1  skid buffer accepts
fetch_to_skid_pc  out  PC_W  PC of head instruction
fetch_to_skid_instr  out  INSTR_W  head instruction
pc_wrap  out  1  1-cycle pulse when the issued PC wraps to 0
fetch_count  out  32  instructions accepted downstream (wraps mod 2^32)

Note: fetch_to_cache_en direction is "out"; the duplicated token above is a typo to be read as: fetch_to_cache_en  out  1.

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-low.
- Reset (rst=0 at a posedge):
  - next_pc=RESET_PC; queue empty; inflight=0; fetch_count=0.
  - fetch_to_skid_valid=0, fetch_to_skid_pc=0, fetch_to_skid_instr=0, pc_wrap=0, fetch_to_cache_en=0.
  - fetch_to_cache_pc=RESET_PC.
  - Reset overrides redirect, push and pop in the same cycle.
- State:
  - next_pc: PC_W-bit register.
  - inflight: 1 bit, an issue was made last cycle.
  - inflight_pc: PC of that issue.
  - inflight_kill: 1 bit, its data must be discarded.
  - Queue: DEPTH entries with rd/wr pointers and count (0..DEPTH).
- pop = fetch_to_skid_valid & fetch_to_skid_ready & !redirect_valid.
- Issue rule, normal: issue = (count + inflight - pop) < DEPTH.
  - This allows full throughput at DEPTH=2 with ready held high.
  - When issuing: fetch_to_cache_pc = next_pc, then next_pc <= next_pc+4 (mod 2^PC_W).
  - When not issuing: fetch_to_cache_pc = next_pc and en=0.
- Return: if inflight & !inflight_kill, push {inflight_pc, cache_rdata} at the queue tail.
  - The issue rule guarantees the queue is never full on a push; overflow is an assertion failure.
- Redirect (redirect_valid=1, rst=1):
  - Queue is flushed (count<=0, pointers reset); any in-flight return is discarded.
  - fetch_to_skid_valid is forced 0 in this cycle.
  - Issue is unconditional: fetch_to_cache_pc = {redirect_pc[PC_W-1:2],2'b00}, next_pc <= that+4.
  - The new issue sets inflight=1, inflight_kill=0.
  - A second redirect in the following cycle supersedes the first in the same way.
- Output:
  - fetch_to_skid_valid = (count != 0) & !redirect_valid.
  - pc and instr come from the queue head.
  - Head fields must be stable while valid & !ready (no ready-dependent change of head).
- Latency: an issue at cycle t is visible at fetch_to_skid_valid at t+2 (data arrives t+1, registered into the queue at end of t+1).
- pc_wrap: registered and asserted for the one cycle following an issue whose address is 0 and whose predecessor issue address was 2^PC_W-4.
  - Redirects to 0 do not pulse.
- fetch_count increments by 1 on each pop.
- Boundary cases:
  - Ready low indefinitely: at most DEPTH entries are held; issue stops, with no re-issue and no skip.
  - Redirect in the same cycle as a would-be pop: the pop is suppressed and fetch_count is unchanged.

Test Plan:
1. mem[i]=i, ready=1, release reset at cycle 0 -> valid from cycle 2; pc 0x000,0x004,0x008,... on consecutive cycles with instr 0,1,2; fetch_count=N after N pops.
2. Ready low for 5 cycles while head=0x008 -> head stays 0x008/instr 2, at most DEPTH=2 queued, en=0 once full; on ready high the pcs continue 0x008,0x00C,0x010 with no duplicate or gap.
3. Redirect to 0x041 with queue full and one in-flight -> valid=0 that cycle, fetch_to_cache_pc=0x040, next valid pc=0x040 exactly 2 cycles later, no stale pc emitted.
4. Run through 0x1F8,0x1FC -> next issued pc 0x000, pc_wrap high exactly 1 cycle, output order 0x1FC then 0x000.
5. rst=0 for one cycle with queue full and ready low -> next cycle valid=0, fetch_count=0, fetch_to_cache_pc=0x000; fetch resumes from 0x000.
6. Redirect with valid=1 and ready=1 simultaneously -> no handshake counted, fetch_count unchanged, head after flush is the redirect target.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Drives the PC stream into a BRAM with a 1-cycle
// registered read, collects the returned words in a small queue and presents
// {pc, instr} downstream over valid/ready. A redirect flushes the queue and
// restarts fetch at the redirect target.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   redirect_valid/_pc       flush and restart fetch (pc[1:0] ignored)
//   fetch_to_cache_en/_pc    BRAM read enable and byte address (this cycle)
//   cache_rdata              BRAM data, valid the cycle after an issue
//   fetch_to_skid_valid      queue head valid
//   fetch_to_skid_ready      downstream accepts the head
//   fetch_to_skid_pc/_instr  head PC and instruction
//   pc_wrap                  1-cycle pulse after the PC stream wraps to 0
//   fetch_count              instructions accepted downstream (mod 2^32)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned PC_W     = 9,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               fetch_to_cache_en,
    output logic [PC_W-1:0]    fetch_to_cache_pc,
    input  logic [INSTR_W-1:0] cache_rdata,
    output logic               fetch_to_skid_valid,
    input  logic               fetch_to_skid_ready,
    output logic [PC_W-1:0]    fetch_to_skid_pc,
    output logic [INSTR_W-1:0] fetch_to_skid_instr,
    output logic               pc_wrap,
    output logic [31:0]        fetch_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    // count reaches DEPTH; with DEPTH a power of two, count+inflight also fits
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PC_W-1:0] LAST_PC = {{(PC_W-2){1'b1}}, 2'b00};

    logic [PC_W-1:0]    next_pc_q, next_pc_d;
    logic               inflight_q, inflight_d;
    logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
    logic               inflight_kill_q, inflight_kill_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pc_wrap_q, pc_wrap_d;
    logic               wrap_armed_q, wrap_armed_d;
    logic [31:0]        fetch_count_q, fetch_count_d;

    logic [PC_W-1:0]    mem_pc_q    [DEPTH];
    logic [INSTR_W-1:0] mem_instr_q [DEPTH];

    logic               head_valid;
    logic               pop;
    logic               push;
    logic               issue;
    logic [CNT_W-1:0]   occupancy;
    logic [PC_W-1:0]    redirect_pc_al;
    logic [PC_W-1:0]    issue_pc;
    logic               unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Handshake, issue decision and next-state
    always_comb begin
        redirect_pc_al  = {redirect_pc[PC_W-1:2], 2'b00};
        head_valid      = (count_q != '0);
        pop             = rst & head_valid & fetch_to_skid_ready & ~redirect_valid;
        push            = inflight_q & ~inflight_kill_q & ~redirect_valid;
        // queued + outstanding entries after this cycle's pop
        occupancy       = count_q + CNT_W'(inflight_q) - CNT_W'(pop);
        issue_pc        = redirect_valid ? redirect_pc_al : next_pc_q;
        if (!rst) begin
            issue = 1'b0;
        end else if (redirect_valid) begin
            issue = 1'b1;
        end else begin
            issue = (occupancy < CNT_W'(DEPTH));
        end

        next_pc_d       = next_pc_q;
        inflight_d      = issue;
        inflight_pc_d   = inflight_pc_q;
        inflight_kill_d = inflight_kill_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        count_d         = count_q;
        pc_wrap_d       = 1'b0;
        wrap_armed_d    = wrap_armed_q;
        fetch_count_d   = fetch_count_q;

        if (issue) begin
            next_pc_d       = issue_pc + PC_W'(4);
            inflight_pc_d   = issue_pc;
            inflight_kill_d = 1'b0;
            // a wrap is an issue of 0 directly following an issue of LAST_PC
            pc_wrap_d       = ~redirect_valid & wrap_armed_q & (issue_pc == '0);
            wrap_armed_d    = (issue_pc == LAST_PC);
        end

        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        if (pop) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            next_pc_q       <= PC_W'(RESET_PC);
            inflight_q      <= 1'b0;
            inflight_pc_q   <= '0;
            inflight_kill_q <= 1'b0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            pc_wrap_q       <= 1'b0;
            wrap_armed_q    <= 1'b0;
            fetch_count_q   <= '0;
        end else begin
            next_pc_q       <= next_pc_d;
            inflight_q      <= inflight_d;
            inflight_pc_q   <= inflight_pc_d;
            inflight_kill_q <= inflight_kill_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            pc_wrap_q       <= pc_wrap_d;
            wrap_armed_q    <= wrap_armed_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
            mem_instr_q[wr_ptr_q] <= cache_rdata;
        end
    end

    // The issue rule keeps count+inflight <= DEPTH, so a push never meets a full queue
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push && (count_q == CNT_W'(DEPTH))));
        end
    end

    assign fetch_to_cache_en   = issue;
    assign fetch_to_cache_pc   = rst ? issue_pc : PC_W'(RESET_PC);
    assign fetch_to_skid_valid = rst & head_valid & ~redirect_valid;
    assign fetch_to_skid_pc    = head_valid ? mem_pc_q[rd_ptr_q]    : '0;
    assign fetch_to_skid_instr = head_valid ? mem_instr_q[rd_ptr_q] : '0;
    assign pc_wrap             = pc_wrap_q;
    assign fetch_count         = fetch_count_q;

endmodule
